// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and sizing helpers for the FIFO-draining UART
// transmitter.
//   state_t     : transmitter FSM states
//   frame_bits  : serial bits per frame (start + data + parity + stop)
//   cnt_width   : width of the per-bit clock down-counter
//   idx_width   : width of the bit index used within DATA and STOP
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n_bits);
        return (n_bits <= 2) ? 1 : $clog2(n_bits);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-port bundle between the FIFO and its reader.
//   fifo_empty : FIFO empty flag            (FIFO -> reader)
//   fifo_data  : FIFO data_out, valid the cycle after a pop (FIFO -> reader)
//   fifo_rd_en : one-cycle pop strobe       (reader -> FIFO)
// master = reader side, slave = FIFO side.
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit down-counter for the serial transmitter.
//   clk, rst : clock, synchronous active-high reset (counter cleared)
//   load     : restart the count at CLKS_PER_BIT-1 (start of a frame)
//   bit_end  : high on the last clk cycle of the current serial bit
// The counter reloads itself at every bit boundary, so each bit is exactly
// CLKS_PER_BIT cycles and no error accumulates across a frame.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic bit_end
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bit_end = (cnt_q == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO and sends each as an async serial
// frame: start bit, DATA_W data bits LSB first, optional parity, stop bits.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : permits starting new frames (a running frame always finishes)
//   fifo       : FIFO read port (master modport: empty/data in, rd_en out)
//   tx         : registered serial line, idles high
//   busy       : high from the cycle after the pop through the last stop cycle
//   frame_done : one-cycle pulse on the last cycle of the final stop bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_uart_tx_if.master       fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int unsigned N     = frame_bits(DATA_W, PARITY_EN, STOP_BITS);
    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = idx_width(N);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              rd_en;
    logic              timer_load;
    logic              bit_end;
    logic              done;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        parity_d   = parity_q;
        rd_en      = 1'b0;
        timer_load = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rst gate keeps the pop strobe off during a reset cycle
                if (enable && !fifo.fifo_empty && !rst) begin
                    rd_en   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d    = fifo.fifo_data;
                bit_d      = '0;
                parity_d   = (^fifo.fifo_data) ^ (PARITY_ODD != 0);
                timer_load = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IDX_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == IDX_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered: its next value is the line level of the state
        // being entered, so the line changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign fifo.fifo_rd_en = rd_en;
    assign tx              = tx_q;
    assign busy            = (state_q != S_IDLE);
    assign frame_done      = done;
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain side of the synchronous FIFO: pops bytes from the FIFO read port and transmits each as an asynchronous serial frame (start bit, data LSB first, optional parity, stop bits) on a single line. Sits between the FIFO and the chip pin. It is the FIFO's only reader and never pops when the FIFO reports empty.

## Interface
Parameters:
- DATA_W, 8: data bits per frame; matches FIFO width.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be 2 or more.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits starting new frames.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after a pop.
- fifo_rd_en  out  1  FIFO read_enable; one-cycle pop strobe.
- tx  out  1  serial line; idles high; registered.
- busy  out  1  high from pop through the final stop-bit cycle.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If enable=1 and fifo_empty=0, assert fifo_rd_en this cycle (combinational from state, enable and fifo_empty), then go to LOAD. Otherwise fifo_rd_en=0.
- LOAD: capture fifo_data into the shift register, clear the bit counter, set parity accumulator, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: shift out DATA_W bits LSB first, CLKS_PER_BIT cycles each. Then go to PARITY if PARITY_EN=1, else STOP.
- PARITY: drive XOR of the data bits (even) or its inverse (odd) for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 on the last cycle. Next state IDLE.
- Frame bits N = 1 + DATA_W + PARITY_EN + STOP_BITS.
- fifo_empty and fifo_data are ignored outside IDLE and LOAD respectively.
- enable dropping mid-frame: the current frame completes and no further pop occurs.
- fifo_rd_en is never asserted while fifo_empty=1, while rst=1, or in any state other than IDLE.

## Timing
- Reset (rst=1 at an edge): state IDLE, tx=1, busy=0, fifo_rd_en=0, frame_done=0, shift register and counters zero.
- Reset mid-frame: tx=1 from the next cycle. The in-flight byte is dropped and not re-popped.
- Let T0 be the pop cycle (fifo_rd_en=1):
  - busy=1 from T0+1.
  - tx=0 from T0+2 through T0+1+CLKS_PER_BIT.
  - Data bit i occupies T0+2+CLKS_PER_BIT*(1+i) for CLKS_PER_BIT cycles.
  - frame_done and the last busy cycle are at T0+1+CLKS_PER_BIT*N.
- Back-to-back frames: the earliest next pop is T0+2+CLKS_PER_BIT*N. The next start bit begins 2 cycles later. Minimum inter-frame gap is 2 idle-high cycles beyond the stop bits.
- Bit timing comes from a down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary. No drift across the frame.

## Structure
- Package fifo_uart_pkg contains:
  - the state enum typedef;
  - a localparam/function computing N from the parameters;
  - width constants (counter width $clog2(CLKS_PER_BIT), bit-index width $clog2(N)).
- Sub-module uart_bit_timer: loadable down-counter with a bit_end pulse, restarted at LOAD. The top level holds the FSM, shift register, parity and output registers.

## Test plan
Bench parameters: CLKS_PER_BIT=4, DATA_W=8.
- Reset then idle, fifo_empty=1, enable=1 for 100 cycles -> tx=1, fifo_rd_en never 1, busy=0.
- Single byte 8'hA5, PARITY_EN=0, STOP_BITS=1 -> tx samples at bit centres read 0,1,0,1,0,0,1,0,1,1. frame_done at T0+41. Exactly one pop.
- Three queued bytes 8'h00, 8'hFF, 8'h3C with enable held -> 3 pops, pops 42 cycles apart, frames in order, 2 idle cycles between frames.
- PARITY_EN=1: 8'h07 gives even parity bit 1; 8'h07 with PARITY_ODD=1 gives parity bit 0. STOP_BITS=2 stretches the frame to 48 cycles.
- rst asserted in DATA bit 3 of 8'h55 -> tx=1 next cycle, busy=0, no frame_done. The next FIFO byte is transmitted cleanly after rst drops.
- enable dropped during START with 2 bytes queued -> the current frame finishes, no further pop until enable returns.
